// File: rtl/seq_divider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seq_divider_pkg                                            |
// | Brief   : Shared ALU opcodes and divider state encodings.            |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package seq_divider_pkg;

    localparam logic [1:0] c_op_add = 2'd0;
    localparam logic [1:0] c_op_sub = 2'd1;
    localparam logic [1:0] c_op_mul = 2'd2;
    localparam logic [1:0] c_op_div = 2'd3;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seq_divider_div_step                                       |
// | Brief   : One restoring shift/trial-subtract step, combinational.    |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_divider_div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] i_rem,
    input  logic [WIDTH:0] i_dq,
    input  logic [WIDTH:0] i_dvs_mag,
    output logic [WIDTH:0] o_rem,
    output logic [WIDTH:0] o_dq
);

    logic [WIDTH+1:0] w_rem_sh;
    logic [WIDTH+1:0] w_trial;

    // One extra bit on the trial so its MSB is a reliable borrow/sign.
    always_comb begin
        w_rem_sh = {i_rem, i_dq[WIDTH]};
        w_trial  = w_rem_sh - {1'b0, i_dvs_mag};
        if (!w_trial[WIDTH+1]) begin
            o_rem = w_trial[WIDTH:0];
            o_dq  = {i_dq[WIDTH-1:0], 1'b1};
        end else begin
            o_rem = w_rem_sh[WIDTH:0];
            o_dq  = {i_dq[WIDTH-1:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seq_divider                                                |
// | Brief   : Sequential signed restoring divider, one bit per clock.    |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o,
    output logic             overflow_o
);

    localparam int               c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_min  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t         r_state;
    div_state_t         w_next_state;
    logic               w_accept;

    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dvd;
    logic               r_dvs_neg;
    logic [WIDTH:0]     r_dvs_mag;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH:0]     r_dq;

    logic [WIDTH:0]     w_dvd_ext;
    logic [WIDTH:0]     w_dvs_ext;
    logic [WIDTH:0]     w_dvd_mag;
    logic [WIDTH:0]     w_dvs_mag;
    logic [WIDTH:0]     w_rem_next;
    logic [WIDTH:0]     w_dq_next;
    logic               w_q_neg;
    logic               w_ovf;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_zero;
    logic               r_overflow;

    // Sign-extend before negating so the most negative value keeps its magnitude.
    assign w_dvd_ext = {dividend_i[WIDTH-1], dividend_i};
    assign w_dvs_ext = {divisor_i[WIDTH-1], divisor_i};
    assign w_dvd_mag = dividend_i[WIDTH-1] ? (~w_dvd_ext + 1'b1) : w_dvd_ext;
    assign w_dvs_mag = divisor_i[WIDTH-1]  ? (~w_dvs_ext + 1'b1) : w_dvs_ext;

    assign w_q_neg = r_dvd[WIDTH-1] ^ r_dvs_neg;
    assign w_ovf   = (r_dvd == c_min) && r_dvs_neg && (r_dvs_mag == (WIDTH+1)'(1));

    seq_divider_div_step #(
        .WIDTH     (WIDTH)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_dq      (r_dq),
        .i_dvs_mag (r_dvs_mag),
        .o_rem     (w_rem_next),
        .o_dq      (w_dq_next)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (start_i) begin
                    w_accept     = 1'b1;
                    w_next_state = (divisor_i == '0) ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (r_cnt == c_last) begin
                    w_next_state = DIV_DONE;
                end
            end
            DIV_DONE: begin
                w_next_state = DIV_IDLE;
            end
            default: begin
                w_next_state = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs_neg   <= 1'b0;
            r_dvs_mag   <= '0;
            r_rem       <= '0;
            r_dq        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_dvd     <= dividend_i;
                r_dvs_neg <= divisor_i[WIDTH-1];
                r_dvs_mag <= w_dvs_mag;
                // Pre-shift so the WIDTH magnitude bits feed in over WIDTH steps.
                r_dq      <= w_dvd_mag << 1;
                r_rem     <= '0;
                r_cnt     <= '0;
                r_busy    <= 1'b1;
            end else if (r_state == DIV_CALC) begin
                r_rem <= w_rem_next;
                r_dq  <= w_dq_next;
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == DIV_DONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                if (r_dvs_mag == '0) begin
                    r_quotient  <= '0;
                    r_remainder <= r_dvd;
                    r_div_zero  <= 1'b1;
                    r_overflow  <= 1'b0;
                end else begin
                    r_quotient  <= WIDTH'(w_q_neg ? (~r_dq + 1'b1) : r_dq);
                    r_remainder <= WIDTH'(r_dvd[WIDTH-1] ? (~r_rem + 1'b1) : r_rem);
                    r_div_zero  <= 1'b0;
                    r_overflow  <= w_ovf;
                end
            end
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign quotient_o  = r_quotient;
    assign remainder_o = r_remainder;
    assign div_zero_o  = r_div_zero;
    assign overflow_o  = r_overflow;

endmodule
`default_nettype wire
